// File: rtl/vga_capture_if.sv
// VGA receive pins plus the frame buffer write port and link status of vga_capture.
interface vga_capture_if;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [2:0]  vga_rgb;
  logic        pixel_wr;
  logic [15:0] pixel_address;
  logic [2:0]  pixel_data;
  logic        frame_start;
  logic        locked;
  logic        sync_error;

  // Handshake: pixel_wr is a one-cycle write strobe with no ready; the sink accepts every write, and
  // pixel_address/pixel_data are meaningful only while pixel_wr is high (they hold otherwise).
  modport master (
    output vga_hsync, vga_vsync, vga_rgb,
    input  pixel_wr, pixel_address, pixel_data, frame_start, locked, sync_error
  );

  modport slave (
    input  vga_hsync, vga_vsync, vga_rgb,
    output pixel_wr, pixel_address, pixel_data, frame_start, locked, sync_error
  );
endinterface

// File: rtl/vga_capture.sv
// VGA receiver: recovers pixel/line position from sync edges, verifies timing, and writes
// decimated active pixels to a frame buffer once the link has locked.
module vga_capture #(
  parameter int HACTIVE     = 640,
  parameter int HFRONTPORCH = 16,
  parameter int HSYNCPULSE  = 96,
  parameter int HBACKPORCH  = 48,
  parameter int VACTIVE     = 480,
  parameter int VFRONTPORCH = 10,
  parameter int VSYNCPULSE  = 2,
  parameter int VBACKPORCH  = 33,
  parameter int HSHIFT      = 2,
  parameter int VSHIFT      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic         clock,
  input  logic         reset,
  vga_capture_if.slave bus,
  output logic [1:0]   state_dbg
);
  localparam int HTOTAL = HACTIVE + HFRONTPORCH + HSYNCPULSE + HBACKPORCH;
  localparam int VTOTAL = VACTIVE + VFRONTPORCH + VSYNCPULSE + VBACKPORCH;
  localparam int HOFS   = HSYNCPULSE + HBACKPORCH;
  localparam int VOFS   = VSYNCPULSE + VBACKPORCH;
  localparam int CW     = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

  localparam logic [10:0]   H_MAX    = 11'd2047;
  localparam logic [9:0]    V_MAX    = 10'd1023;
  localparam logic [10:0]   H_LO     = 11'(HOFS);
  localparam logic [10:0]   H_HI     = 11'(HOFS + HACTIVE);
  localparam logic [9:0]    V_LO     = 10'(VOFS);
  localparam logic [9:0]    V_HI     = 10'(VOFS + VACTIVE);
  localparam logic [10:0]   H_LAST   = 11'(HTOTAL - 1);
  localparam logic [10:0]   HS_LAST  = 11'(HSYNCPULSE - 1);
  localparam logic [9:0]    V_LAST   = 10'(VTOTAL - 1);
  localparam logic [10:0]   H_MASK   = 11'((1 << HSHIFT) - 1);
  localparam logic [9:0]    V_MASK   = 10'((1 << VSHIFT) - 1);
  localparam logic [15:0]   ROW_W    = 16'(HACTIVE >> HSHIFT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        hs1, hs2, vs1, vs2;
  logic [2:0]  rgb1;
  logic [10:0] h_q, h_pos, hx;
  logic [9:0]  v_q, v_line, vy;
  logic        h_valid;
  logic        hs_fall, hs_rise, vs_fall;
  logic        check_fail, in_active, keep, wr_c;
  logic [15:0] addr_c;

  assign hs_fall = !hs1 && hs2;
  assign hs_rise = hs1 && !hs2;
  assign vs_fall = !vs1 && vs2;

  // Position of the sample currently in s1; a sync fall restarts the count in the same cycle.
  always_comb begin
    h_pos = h_q;
    if (hs_fall)          h_pos = '0;
    else if (h_q != H_MAX) h_pos = h_q + 11'd1;
    v_line = v_q;
    if (vs_fall)                     v_line = '0;
    else if (hs_fall && v_q != V_MAX) v_line = v_q + 10'd1;
  end

  // Line and pulse checks need a real hsync fall behind h_q; in SEARCH nothing is reported.
  assign check_fail = (state_q != SEARCH) &&
                      ((hs_fall && h_valid && (h_q != H_LAST)) ||
                       (hs_rise && h_valid && (h_q != HS_LAST)) ||
                       (vs_fall && (v_q != V_LAST)) ||
                       (h_pos == H_MAX));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = ACQUIRE;
          cnt_d   = '0;
        end
      end
      ACQUIRE: begin
        if (check_fail) begin
          state_d = SEARCH;
          cnt_d   = '0;
        end else if (vs_fall) begin
          if (cnt_q == CNT_LAST) state_d = LOCKED;
          else                   cnt_d = cnt_q + CW'(1);
        end
      end
      LOCKED: begin
        if (check_fail) begin
          state_d = SEARCH;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        cnt_d   = '0;
      end
    endcase
  end

  assign hx        = h_pos - H_LO;
  assign vy        = v_line - V_LO;
  assign in_active = (h_pos >= H_LO) && (h_pos < H_HI) && (v_line >= V_LO) && (v_line < V_HI);
  assign keep      = ((hx & H_MASK) == '0) && ((vy & V_MASK) == '0);
  assign wr_c      = (state_d == LOCKED) && in_active && keep;
  assign addr_c    = 16'(vy >> VSHIFT) * ROW_W + 16'(hx >> HSHIFT);
  assign state_dbg = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hs1     <= 1'b0;
      hs2     <= 1'b0;
      vs1     <= 1'b0;
      vs2     <= 1'b0;
      rgb1    <= '0;
      state_q <= SEARCH;
      cnt_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      h_valid <= 1'b0;
    end else begin
      hs1     <= bus.vga_hsync;
      hs2     <= hs1;
      vs1     <= bus.vga_vsync;
      vs2     <= vs1;
      rgb1    <= bus.vga_rgb;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_pos;
      v_q     <= v_line;
      h_valid <= h_valid | hs_fall;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.pixel_wr      <= 1'b0;
      bus.pixel_address <= '0;
      bus.pixel_data    <= '0;
      bus.frame_start   <= 1'b0;
      bus.locked        <= 1'b0;
      bus.sync_error    <= 1'b0;
    end else begin
      bus.pixel_wr <= wr_c;
      if (wr_c) begin
        bus.pixel_address <= addr_c;
        bus.pixel_data    <= rgb1;
      end
      bus.frame_start <= vs_fall && (state_d == LOCKED);
      bus.locked      <= (state_d == LOCKED);
      bus.sync_error  <= check_fail;
    end
  end
endmodule
